// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the single-port pipelined RAM slice.
//   - FSM state encodings (clear sweep / ready)
//   - write-response mode selectors for RW_MODE
//   - even-parity helper used when parity storage is enabled
package mem_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam int unsigned RW_NONE    = 0;  // writes produce no response
  localparam int unsigned RW_RDFIRST = 1;  // write response carries old data
  localparam int unsigned RW_WRFIRST = 2;  // write response carries new data

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_sp_pipe_if.sv
// mem_sp_pipe_if: request/response bus of mem_sp_pipe.
//   req_valid/req_ready  request handshake (accept = valid && ready)
//   req_we               1 = write, 0 = read
//   req_addr, req_din    word address and write data
//   rsp_valid            one-cycle response strobe
//   rsp_dout             response data, held while rsp_valid = 0
//   rsp_err, rsp_perr    range / parity error flags qualified by rsp_valid
// Modports: master drives requests, slave (the memory) drives responses.
interface mem_sp_pipe_if #(
  parameter int unsigned DATA_W = 25,
  parameter int unsigned ADDR_W = 11
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_din;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_dout;
  logic              rsp_err;
  logic              rsp_perr;

  modport master (
    output req_valid, req_we, req_addr, req_din,
    input  req_ready, rsp_valid, rsp_dout, rsp_err, rsp_perr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_din,
    output req_ready, rsp_valid, rsp_dout, rsp_err, rsp_perr
  );

endinterface

// File: rtl/mem_sp_array.sv
// mem_sp_array: plain inferred single-port block RAM, no reset.
//   clk   rising-edge clock
//   en    access enable (read and/or write this cycle)
//   we    write enable, qualified by en
//   addr  word address (must be < DEPTH when en is high)
//   din   write data
//   dout  registered read data, updated only on enabled cycles
// WRITE_FIRST selects whether a write returns the new word (1) or the
// word previously stored at that address (0).
module mem_sp_array #(
  parameter int unsigned WIDTH       = 25,
  parameter int unsigned DEPTH       = 2000,
  parameter int unsigned ADDR_W      = 11,
  parameter bit          WRITE_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      if (WRITE_FIRST && we) begin
        dout_q <= din;
      end else begin
        dout_q <= mem[addr];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/mem_sp_pipe.sv
// mem_sp_pipe: parametrised single-port RAM with valid/ready requests,
// 1- or 2-cycle read pipeline, selectable write-response mode and a
// hardware clear sweep that zeroes the array after reset or on clr.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        single-cycle pulse, (re)starts the clear sweep
//   init_busy  high while the clear sweep runs
//   bus        mem_sp_pipe_if.slave request/response port
// Optional build macro MEM_SP_PIPE_PARITY_EN: stores an even-parity bit
// with every word and flags mismatches on rsp_perr; otherwise rsp_perr = 0.
module mem_sp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 25,
  parameter int unsigned DEPTH   = 2000,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned RW_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  output logic           init_busy,
  mem_sp_pipe_if.slave   bus
);

`ifdef MEM_SP_PIPE_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              p1_valid_q, p1_valid_d;
  logic              p1_err_q, p1_err_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_dout_q, out_dout_d;
  logic              out_err_q, out_err_d;
  logic              out_perr_q, out_perr_d;

  logic              clearing;
  logic              accept;
  logic              in_range;
  logic              rsp_req;

  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [MEM_W-1:0]  arr_din;
  logic [MEM_W-1:0]  arr_rd;
  logic [MEM_W-1:0]  wr_word;

  logic [DATA_W-1:0] s1_data;
  logic              s1_perr;

  // ---------------------------------------------------------------------
  // Control: clear sweep FSM and request acceptance
  // ---------------------------------------------------------------------
  assign clearing      = (state_q == ST_CLEAR);
  assign init_busy     = clearing;
  assign bus.req_ready = (state_q == ST_READY);
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_range      = ({1'b0, bus.req_addr} < DEPTH_C);
  assign rsp_req       = accept && (!bus.req_we || (RW_MODE != RW_NONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // A request accepted alongside clr has already been steered to the
        // array this cycle; only later requests see req_ready low.
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Array port: the sweep owns the port while clearing, otherwise only
  // in-range accepted requests touch the array.
  // ---------------------------------------------------------------------
`ifdef MEM_SP_PIPE_PARITY_EN
  assign wr_word = {even_parity(64'(bus.req_din)), bus.req_din};
`else
  assign wr_word = bus.req_din;
`endif

  always_comb begin
    arr_en   = clearing || (accept && in_range);
    arr_we   = clearing || bus.req_we;
    arr_addr = clearing ? cnt_q : bus.req_addr;
    arr_din  = clearing ? '0 : wr_word;
  end

  mem_sp_array #(
    .WIDTH       (MEM_W),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .WRITE_FIRST (RW_MODE == RW_WRFIRST)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .din  (arr_din),
    .dout (arr_rd)
  );

  // ---------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------
  always_comb begin
    p1_valid_d = rsp_req;
    p1_err_d   = !in_range;
  end

  // Out-of-range responses force zero data and never report parity.
  always_comb begin
    s1_data = p1_err_q ? '0 : arr_rd[DATA_W-1:0];
`ifdef MEM_SP_PIPE_PARITY_EN
    s1_perr = !p1_err_q &&
              (arr_rd[DATA_W] != even_parity(64'(arr_rd[DATA_W-1:0])));
`else
    s1_perr = 1'b0;
`endif
  end

  // out_dout_q doubles as the hold register for rsp_dout in both latencies.
  always_comb begin
    out_valid_d = p1_valid_q;
    out_dout_d  = p1_valid_q ? s1_data : out_dout_q;
    out_err_d   = p1_valid_q && p1_err_q;
    out_perr_d  = p1_valid_q && s1_perr;
  end

  always_comb begin
    if (RD_LAT == 2) begin
      bus.rsp_valid = out_valid_q;
      bus.rsp_dout  = out_dout_q;
      bus.rsp_err   = out_err_q;
      bus.rsp_perr  = out_perr_q;
    end else begin
      bus.rsp_valid = p1_valid_q;
      bus.rsp_dout  = out_dout_d;
      bus.rsp_err   = out_err_d;
      bus.rsp_perr  = out_perr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      p1_valid_q  <= 1'b0;
      p1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_dout_q  <= '0;
      out_err_q   <= 1'b0;
      out_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_valid_q  <= p1_valid_d;
      p1_err_q    <= p1_err_d;
      out_valid_q <= out_valid_d;
      out_dout_q  <= out_dout_d;
      out_err_q   <= out_err_d;
      out_perr_q  <= out_perr_d;
    end
  end

endmodule

// File: tb/tb_mem_sp_pipe.sv
// tb_mem_sp_pipe: directed bench for mem_sp_pipe. Three instances share
// one request stream and reset/clear:
//   dut_a  RD_LAT=1, RW_MODE=0 (no write response)
//   dut_b  RD_LAT=1, RW_MODE=1 (read-first write response)
//   dut_c  RD_LAT=2, RW_MODE=2 (write-first write response)
// Define MEM_SP_PIPE_PARITY_EN for the whole build to add the parity case.
module tb_mem_sp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        busy_a, busy_b, busy_c;
  logic        req_valid;
  logic        req_we;
  logic [10:0] req_addr;
  logic [24:0] req_din;

  int checks = 0;
  int errors = 0;

  mem_sp_pipe_if #(.DATA_W(25), .ADDR_W(11)) if_a ();
  mem_sp_pipe_if #(.DATA_W(25), .ADDR_W(11)) if_b ();
  mem_sp_pipe_if #(.DATA_W(25), .ADDR_W(11)) if_c ();

  assign if_a.req_valid = req_valid;
  assign if_a.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_a.req_din   = req_din;
  assign if_b.req_valid = req_valid;
  assign if_b.req_we    = req_we;
  assign if_b.req_addr  = req_addr;
  assign if_b.req_din   = req_din;
  assign if_c.req_valid = req_valid;
  assign if_c.req_we    = req_we;
  assign if_c.req_addr  = req_addr;
  assign if_c.req_din   = req_din;

  mem_sp_pipe #(.DATA_W(25), .DEPTH(2000), .ADDR_W(11), .RD_LAT(1), .RW_MODE(0))
    dut_a (.clk(clk), .rst(rst), .clr(clr), .init_busy(busy_a), .bus(if_a));
  mem_sp_pipe #(.DATA_W(25), .DEPTH(2000), .ADDR_W(11), .RD_LAT(1), .RW_MODE(1))
    dut_b (.clk(clk), .rst(rst), .clr(clr), .init_busy(busy_b), .bus(if_b));
  mem_sp_pipe #(.DATA_W(25), .DEPTH(2000), .ADDR_W(11), .RD_LAT(2), .RW_MODE(2))
    dut_c (.clk(clk), .rst(rst), .clr(clr), .init_busy(busy_c), .bus(if_c));

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [24:0] din;
    logic [24:0] a_d;   // dut_a rsp_dout (held value on writes)
    logic [24:0] b_d;   // dut_b response data
    logic [24:0] c_d;   // dut_c response data
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [10:0] addr, input logic [24:0] din);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_din   = din;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while (busy_a && n < 5000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int  n;
    logic seen;

    vecs[0]  = '{1'b1, 11'd5,    25'h1ABCDEF, 25'h0,       25'h0,       25'h1ABCDEF, 1'b0};
    vecs[1]  = '{1'b0, 11'd5,    25'h0,       25'h1ABCDEF, 25'h1ABCDEF, 25'h1ABCDEF, 1'b0};
    vecs[2]  = '{1'b1, 11'd7,    25'h0000011, 25'h1ABCDEF, 25'h0,       25'h0000011, 1'b0};
    vecs[3]  = '{1'b1, 11'd7,    25'h0000022, 25'h1ABCDEF, 25'h0000011, 25'h0000022, 1'b0};
    vecs[4]  = '{1'b0, 11'd7,    25'h0,       25'h0000022, 25'h0000022, 25'h0000022, 1'b0};
    vecs[5]  = '{1'b0, 11'd2000, 25'h0,       25'h0,       25'h0,       25'h0,       1'b1};
    vecs[6]  = '{1'b0, 11'd2047, 25'h0,       25'h0,       25'h0,       25'h0,       1'b1};
    vecs[7]  = '{1'b1, 11'd2000, 25'h1FFFFFF, 25'h0,       25'h0,       25'h0,       1'b1};
    vecs[8]  = '{1'b0, 11'd0,    25'h0,       25'h0,       25'h0,       25'h0,       1'b0};
    vecs[9]  = '{1'b0, 11'd1999, 25'h0,       25'h0,       25'h0,       25'h0,       1'b0};
    vecs[10] = '{1'b1, 11'd1999, 25'h0000155, 25'h0,       25'h0,       25'h0000155, 1'b0};
    vecs[11] = '{1'b0, 11'd1999, 25'h0,       25'h0000155, 25'h0000155, 25'h0000155, 1'b0};
    vecs[12] = '{1'b1, 11'd0,    25'h1555555, 25'h0000155, 25'h0,       25'h1555555, 1'b0};
    vecs[13] = '{1'b0, 11'd0,    25'h0,       25'h1555555, 25'h1555555, 25'h1555555, 1'b0};
    vecs[14] = '{1'b1, 11'd1,    25'h0001111, 25'h1555555, 25'h0,       25'h0001111, 1'b0};

    rst = 1'b0; clr = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_din = '0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_init_busy", busy_a, 1);
    chk("rst_req_ready", if_a.req_ready, 0);
    chk("rst_rsp_valid_a", if_a.rsp_valid, 0);
    chk("rst_rsp_valid_c", if_c.rsp_valid, 0);
    chk("rst_rsp_dout", if_a.rsp_dout, 0);
    chk("rst_rsp_err", if_a.rsp_err, 0);
    chk("rst_rsp_perr", if_a.rsp_perr, 0);

    // Initial sweep: exactly DEPTH cycles after rst release
    tick(); tick();
    rst = 1'b0;
    sweep_len(n);
    chk("init_sweep_len", n, 2000);
    chk("init_ready", if_a.req_ready, 1);
    chk("init_busy_c", busy_c, 0);

    // Isolated transactions from the vector table
    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].din);
      chk($sformatf("v%0d_a_valid", i), if_a.rsp_valid, !vecs[i].we);
      chk($sformatf("v%0d_a_dout", i), if_a.rsp_dout, vecs[i].a_d);
      if (!vecs[i].we) chk($sformatf("v%0d_a_err", i), if_a.rsp_err, vecs[i].err);
      chk($sformatf("v%0d_b_valid", i), if_b.rsp_valid, 1);
      chk($sformatf("v%0d_b_dout", i), if_b.rsp_dout, vecs[i].b_d);
      chk($sformatf("v%0d_b_err", i), if_b.rsp_err, vecs[i].err);
      chk($sformatf("v%0d_b_perr", i), if_b.rsp_perr, 0);
      chk($sformatf("v%0d_c_early", i), if_c.rsp_valid, 0);
      tick();
      chk($sformatf("v%0d_c_valid", i), if_c.rsp_valid, 1);
      chk($sformatf("v%0d_c_dout", i), if_c.rsp_dout, vecs[i].c_d);
      chk($sformatf("v%0d_c_err", i), if_c.rsp_err, vecs[i].err);
      chk($sformatf("v%0d_a_single", i), if_a.rsp_valid, 0);
      tick();
    end

    // Write addr 6 then read it on the very next cycle
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd6; req_din = 25'h0123456;
    tick();
    chk("b2b_a_wr_norsp", if_a.rsp_valid, 0);
    chk("b2b_b_wr_valid", if_b.rsp_valid, 1);
    chk("b2b_b_wr_old", if_b.rsp_dout, 0);
    req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("b2b_a_rd_valid", if_a.rsp_valid, 1);
    chk("b2b_a_rd_dout", if_a.rsp_dout, 25'h0123456);
    chk("b2b_b_rd_dout", if_b.rsp_dout, 25'h0123456);
    chk("b2b_c_wr_valid", if_c.rsp_valid, 1);
    chk("b2b_c_wr_new", if_c.rsp_dout, 25'h0123456);
    tick();
    chk("b2b_c_rd_valid", if_c.rsp_valid, 1);
    chk("b2b_c_rd_dout", if_c.rsp_dout, 25'h0123456);
    chk("b2b_a_idle", if_a.rsp_valid, 0);
    tick();

    // clr with a read accepted in the same cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd7; clr = 1'b1;
    tick();
    clr = 1'b0; req_valid = 1'b0;
    chk("clr_rd_valid", if_a.rsp_valid, 1);
    chk("clr_rd_dout", if_a.rsp_dout, 25'h0000022);
    chk("clr_ready_low", if_a.req_ready, 0);
    chk("clr_busy", busy_a, 1);
    sweep_len(n);
    chk("clr_sweep_len", n, 2000);
    do_req(1'b0, 11'd7, 25'h0);
    chk("clr_zeroed_valid", if_a.rsp_valid, 1);
    chk("clr_zeroed_dout", if_a.rsp_dout, 0);
    tick(); tick();

    // RD_LAT=2 reads 1,2,3 back to back, reset at the second response
    do_req(1'b1, 11'd1, 25'h0001111);
    tick(); tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd1;
    tick();
    req_addr = 11'd2;
    tick();
    chk("rst_mid_c_first_valid", if_c.rsp_valid, 1);
    chk("rst_mid_c_first_dout", if_c.rsp_dout, 25'h0001111);
    req_addr = 11'd3;
    tick();
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("rst_mid_c_valid", if_c.rsp_valid, 0);
    chk("rst_mid_c_dout", if_c.rsp_dout, 0);
    chk("rst_mid_busy", busy_c, 1);
    tick(); tick();
    rst = 1'b0;
    seen = 1'b0; n = 0;
    while (busy_c && n < 5000) begin
      tick();
      n++;
      if (if_c.rsp_valid) seen = 1'b1;
    end
    chk("rst_mid_sweep_len", n, 2000);
    chk("rst_mid_no_stale_rsp", seen, 0);
    do_req(1'b0, 11'd1, 25'h0);
    tick();
    chk("rst_mid_post_valid", if_c.rsp_valid, 1);
    chk("rst_mid_post_dout", if_c.rsp_dout, 0);
    tick();

`ifdef MEM_SP_PIPE_PARITY_EN
    do_req(1'b1, 11'd9, 25'h0000003); tick(); tick();
    do_req(1'b1, 11'd10, 25'h0000003); tick(); tick();
    dut_a.u_array.mem[9] = dut_a.u_array.mem[9] ^ 26'd1;
    do_req(1'b0, 11'd9, 25'h0);
    chk("par_flip_valid", if_a.rsp_valid, 1);
    chk("par_flip_perr", if_a.rsp_perr, 1);
    tick(); tick();
    do_req(1'b0, 11'd10, 25'h0);
    chk("par_ok_perr", if_a.rsp_perr, 0);
    chk("par_ok_dout", if_a.rsp_dout, 25'h0000003);
    tick(); tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sp_pipe.md
Name: mem_sp_pipe

Overview:
Parametrised single-port synchronous RAM with a valid/ready request interface, a configurable read pipeline, selectable read-during-write mode and a hardware clear sweep. It is the general successor to the fixed 25x2000 storage block. It sits between sample-capture logic and readout/UART logic wherever on-chip buffering of up to ~50 kbit is needed. Memory contents are never reset directly; a sequential clear FSM zeroes them.

Parameters:
DATA_W, 25, word width in bits (1..64)
DEPTH, 2000, number of words (2..65536)
ADDR_W, 11, address width; must satisfy 2**ADDR_W >= DEPTH
RD_LAT, 1, read latency in cycles from request accept to rsp_valid (1 or 2)
RW_MODE, 0, write response mode: 0 = no response on write, 1 = read-first (old data returned), 2 = write-first (new data returned)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  single-cycle pulse; starts the clear sweep
init_busy  out  1  high while the clear sweep runs
req_valid  in  1  request present
req_ready  out  1  request can be accepted
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_din  in  DATA_W  write data
rsp_valid  out  1  one-cycle response strobe
rsp_dout  out  DATA_W  response data; holds last value when rsp_valid = 0
rsp_err  out  1  qualifies rsp_valid: the address was >= DEPTH
rsp_perr  out  1  qualifies rsp_valid: parity mismatch (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. During rst: FSM = CLEAR, clear counter = 0, init_busy = 1, req_ready = 0, rsp_valid = 0, rsp_dout = 0, rsp_err = 0, rsp_perr = 0, and the read pipeline valid bits are 0.
- FSM states:
  - CLEAR: write 0 to address cnt, cnt++ each cycle. At cnt == DEPTH-1, go to READY. The sweep takes exactly DEPTH cycles after rst deasserts.
  - READY: req_ready = 1, init_busy = 0. A clr pulse moves the FSM to CLEAR with cnt = 0.
- clr during CLEAR restarts the sweep at 0.
- A request accepted in the same cycle as clr is still performed. After that, req_ready drops on the next cycle.
- Accept condition: req_valid && req_ready. Each accepted request is fully processed; there is no back-pressure on responses.
- Read accepted in cycle N:
  - rsp_valid is high in cycle N+RD_LAT with mem[addr].
  - With RD_LAT = 2, an extra output register stage is inserted.
  - Back-to-back reads give one response per cycle.
- Write accepted in cycle N:
  - mem[addr] is updated at the cycle-N edge.
  - RW_MODE 0: no response, and rsp_dout is unchanged.
  - RW_MODE 1: response at N+RD_LAT carrying the pre-write data.
  - RW_MODE 2: response carrying req_din.
- Out-of-range address (addr >= DEPTH):
  - A write is dropped, and no array access is made.
  - A read responds with rsp_dout = 0 and rsp_err = 1.
  - An RW_MODE 1/2 write responds with rsp_err = 1 and rsp_dout = 0.
- A read of the address written in the previous cycle returns the new data; no hazard exists.
- Reset mid-operation: in-flight responses are discarded (no rsp_valid after rst), and the sweep restarts.
- Address counter width is ADDR_W. DEPTH-1 comparison terminates the sweep, so there is no wrap to unused addresses.

Optional Feature:
- Macro MEM_SP_PIPE_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits, the extra bit being even parity of the data. The clear sweep writes parity 0.
  - On read, parity is recomputed. rsp_perr = 1 with rsp_valid when the stored parity mismatches.
  - Out-of-range responses have rsp_perr = 0.
- Not defined: the array is DATA_W bits and rsp_perr is tied to 0.

Decomposition:
- Shared package mem_pkg holds:
  - FSM state encoding (ST_CLEAR = 1'b0, ST_READY = 1'b1).
  - RW_MODE constants RW_NONE = 0, RW_RDFIRST = 1, RW_WRFIRST = 2.
  - A helper function for even parity.
- One sub-module, mem_sp_array: a plain inferred block RAM with width, depth, synchronous write, synchronous read and read-first/write-first selection. It has no reset.
- mem_sp_pipe owns the FSM, range check, pipeline and parity.

Test Plan:
- DEPTH = 2000, rst released at cycle 0: init_busy is high for exactly 2000 cycles, req_ready rises at cycle 2000, and a read of addr 1999 returns 0.
- RD_LAT = 1, write 0x1ABCDEF to addr 5, then read addr 5 on the next cycle: rsp_valid one cycle after the read with rsp_dout = 0x1ABCDEF and rsp_err = 0.
- RW_MODE = 1, addr 7 holds 0x0000011, write 0x0000022 to addr 7: response 0x0000011. Repeat with RW_MODE = 2: response 0x0000022.
- Read addr 2000 and addr 2047: rsp_err = 1 and rsp_dout = 0. A write to addr 2000 leaves addr 0..1999 unchanged.
- RD_LAT = 2, reads of addr 1,2,3 on consecutive cycles, with rst asserted at the second response: only the first rsp_valid is seen, and after release the sweep runs 2000 cycles again.
- PARITY_EN build, force-flip one stored bit at addr 9 via hierarchical deposit, then read addr 9: rsp_perr = 1. Reading addr 10 gives rsp_perr = 0.
